kmer_minhash_engine: RTL

- Sits directly downstream of the window input handler and consumes its outputs.
- Latches one window of WINDOW_SIZE 2-bit bases and slides over every KMER_SIZE-base k-mer, one per cycle.
- Hashes each k-mer with NUM_HASH seeded hash functions and keeps the running minimum per function (MinHash signature).
- Raises hashing_is_done back to the input handler and presents the signature to the LSH bucketing stage.

---
 rtl/kmer_minhash_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/kmer_minhash_engine.sv
// MinHash engine: latches a window of 2-bit bases, hashes every k-mer with NUM_HASH seeded
// hashes and keeps the per-function minimum. Optional macro KMER_MINHASH_MINPOS_EN adds min_pos.
module kmer_minhash_engine #(
  parameter int WINDOW_SIZE = 128,
  parameter int KMER_SIZE   = 16,
  parameter int NUM_HASH    = 4,
  parameter int HASH_W      = 32,
  parameter int ID_W        = 8,
  localparam int NUM_KMERS  = WINDOW_SIZE - KMER_SIZE + 1,
  localparam int POS_W      = (NUM_KMERS > 1) ? $clog2(NUM_KMERS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [0:WINDOW_SIZE-1][1:0]          window,
  input  logic [ID_W-1:0]                      window_id,
  input  logic                                 window_reset,
  input  logic                                 ready_for_hashing,
  output logic                                 hashing_is_done,
  output logic                                 busy,
  output logic [ID_W-1:0]                      sig_id,
  output logic [0:NUM_HASH-1][HASH_W-1:0]      signature
`ifdef KMER_MINHASH_MINPOS_EN
  ,
  output logic [0:NUM_HASH-1][POS_W-1:0]       min_pos
`endif
);

  // Handshake: a window is accepted when ready_for_hashing=1 in IDLE; hashing_is_done stays
  // high in DONE until ready_for_hashing is seen low, and both drop on that same edge.
  typedef enum logic [1:0] {S_IDLE, S_HASH, S_DRAIN, S_DONE} state_t;

  localparam logic [HASH_W-1:0] MULT = HASH_W'(32'h9E3779B1);

  function automatic logic [HASH_W-1:0] seed_f(input int unsigned i);
    logic [63:0] prod;
    prod = 64'(i) * 64'h5BD1E995;
    return prod[HASH_W-1:0];
  endfunction

  state_t                     r_state;
  logic [2*WINDOW_SIZE-1:0]   r_buf;
  logic [POS_W-1:0]           r_p;
  logic                       r_s1_vld;
  logic [HASH_W-1:0]          r_x   [NUM_HASH];
  logic [HASH_W-1:0]          r_min [NUM_HASH];
  logic [HASH_W-1:0]          w_h   [NUM_HASH];
  logic [HASH_W-1:0]          w_k;
`ifdef KMER_MINHASH_MINPOS_EN
  logic [POS_W-1:0]           r_pos1;
  logic [POS_W-1:0]           r_minp [NUM_HASH];
`endif

  // The buffer shifts left one base per HASH cycle, so the current k-mer is always the top bits.
  assign w_k = HASH_W'(r_buf[2*WINDOW_SIZE-1 -: 2*KMER_SIZE]);

  always_comb begin
    for (int i = 0; i < NUM_HASH; i++) begin
      w_h[i] = r_x[i] * MULT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_buf           <= '0;
      r_p             <= '0;
      r_s1_vld        <= 1'b0;
      hashing_is_done <= 1'b0;
      busy            <= 1'b0;
      sig_id          <= '0;
      signature       <= '0;
      for (int i = 0; i < NUM_HASH; i++) begin
        r_x[i]   <= '0;
        r_min[i] <= '1;
      end
`ifdef KMER_MINHASH_MINPOS_EN
      r_pos1  <= '0;
      min_pos <= '0;
      for (int i = 0; i < NUM_HASH; i++) r_minp[i] <= '0;
`endif
    end else if (window_reset) begin
      r_state         <= S_IDLE;
      r_s1_vld        <= 1'b0;
      hashing_is_done <= 1'b0;
      busy            <= 1'b0;
      sig_id          <= '0;
      signature       <= '0;
      for (int i = 0; i < NUM_HASH; i++) r_min[i] <= '1;
`ifdef KMER_MINHASH_MINPOS_EN
      min_pos <= '0;
      for (int i = 0; i < NUM_HASH; i++) r_minp[i] <= '0;
`endif
    end else begin
      // Stage 2: strict less-than, so a tie keeps the earlier position.
      if (r_s1_vld) begin
        for (int i = 0; i < NUM_HASH; i++) begin
          if (w_h[i] < r_min[i]) begin
            r_min[i] <= w_h[i];
`ifdef KMER_MINHASH_MINPOS_EN
            r_minp[i] <= r_pos1;
`endif
          end
        end
      end
      case (r_state)
        S_IDLE: begin
          if (ready_for_hashing) begin
            r_buf    <= window;
            sig_id   <= window_id;
            r_p      <= '0;
            r_s1_vld <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_HASH;
            for (int i = 0; i < NUM_HASH; i++) r_min[i] <= '1;
`ifdef KMER_MINHASH_MINPOS_EN
            for (int i = 0; i < NUM_HASH; i++) r_minp[i] <= '0;
`endif
          end
        end
        S_HASH: begin
          for (int i = 0; i < NUM_HASH; i++) r_x[i] <= w_k ^ seed_f(i);
`ifdef KMER_MINHASH_MINPOS_EN
          r_pos1 <= r_p;
`endif
          r_s1_vld <= 1'b1;
          r_buf    <= r_buf << 2;
          r_p      <= r_p + 1'b1;
          if (r_p == POS_W'(NUM_KMERS - 1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // First DRAIN edge retires the last k-mer; the next one publishes the minima.
          if (r_s1_vld) begin
            r_s1_vld <= 1'b0;
          end else begin
            for (int i = 0; i < NUM_HASH; i++) signature[i] <= r_min[i];
`ifdef KMER_MINHASH_MINPOS_EN
            for (int i = 0; i < NUM_HASH; i++) min_pos[i] <= r_minp[i];
`endif
            hashing_is_done <= 1'b1;
            busy            <= 1'b0;
            r_state         <= S_DONE;
          end
        end
        S_DONE: begin
          if (!ready_for_hashing) begin
            hashing_is_done <= 1'b0;
            r_state         <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
